// File: rtl/bsg_fifo_1r1w_ctrl_width_p9_els_p2.sv
// bsg_fifo_1r1w_ctrl_width_p9_els_p2
//
// Ready/valid sequencer for a small FIFO whose storage is a separate 1r1w
// register-file memory instantiated beside this block in the parent. This
// block owns the read/write pointers, the occupancy count and the handshakes.
// It also drives the memory's write and read ports.
//
// The memory has no same-address forwarding. Writes are only allowed while the
// FIFO is not full. Whenever a read is valid and a write happens in the same
// cycle, the two pointers therefore address different entries.
//
// Optional feature (macro BSG_FIFO_CTRL_ERR_CHK_EN):
//   defined   : a sticky protocol-error flag records enqueue attempts while
//               full and dequeue attempts while empty.
//   undefined : no error register is built and error_o is tied low.
//
// Ports:
//   clk_i         single clock, rising-edge
//   reset_i       asynchronous active-high reset
//   v_i, data_i   producer valid / data
//   ready_o       FIFO can accept (registered state only)
//   v_o, data_o   head valid / head data (data comes from mem_r_data_i)
//   yumi_i        consumer takes the head entry
//   mem_w_*       memory write port (enable, address, data)
//   mem_r_*       memory read port (enable, address, returned data)
//   count_o       current occupancy, 0..els_p
//   error_o       sticky protocol error (0 when checking is compiled out)

module bsg_fifo_1r1w_ctrl_width_p9_els_p2 #(
  parameter int width_p = 9,
  parameter int els_p   = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  input  logic                       yumi_i,
  output logic                       mem_w_v_o,
  output logic [$clog2(els_p)-1:0]   mem_w_addr_o,
  output logic [width_p-1:0]         mem_w_data_o,
  output logic                       mem_r_v_o,
  output logic [$clog2(els_p)-1:0]   mem_r_addr_o,
  input  logic [width_p-1:0]         mem_r_data_i,
  output logic [$clog2(els_p):0]     count_o,
  output logic                       error_o
);

  localparam int ptr_w = $clog2(els_p);

  logic [ptr_w-1:0] wptr_r;
  logic [ptr_w-1:0] rptr_r;
  logic [ptr_w:0]   count_r;
  logic             empty;
  logic             full;
  logic             enq;
  logic             deq;

  // Flags come only from registered state and reset. This keeps ready_o and
  // v_o free of combinational paths from v_i or yumi_i.
  assign empty   = (count_r == '0);
  assign full    = (count_r == (ptr_w+1)'(els_p));
  assign ready_o = ~full & ~reset_i;
  assign v_o     = ~empty;

  assign enq = v_i & ready_o;
  assign deq = yumi_i & v_o;

  assign mem_w_v_o    = enq;
  assign mem_w_addr_o = wptr_r;
  assign mem_w_data_o = data_i;

  assign mem_r_v_o    = v_o;
  assign mem_r_addr_o = rptr_r;
  assign data_o       = mem_r_data_i;

  assign count_o = count_r;

  // Pointers wrap naturally because els_p is a power of two.
  // count_r moves only when exactly one of enq/deq fires. Because enq needs
  // ~full and deq needs ~empty, the count stays within 0..els_p.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq) wptr_r <= wptr_r + ptr_w'(1);
      if (deq) rptr_r <= rptr_r + ptr_w'(1);
      case ({enq, deq})
        2'b10:   count_r <= count_r + (ptr_w+1)'(1);
        2'b01:   count_r <= count_r - (ptr_w+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef BSG_FIFO_CTRL_ERR_CHK_EN
  logic error_r;

  // Sticky: set by a push into a full FIFO or a pop from an empty one, and
  // cleared only by reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      error_r <= 1'b0;
    end else if ((v_i & ~ready_o) | (yumi_i & ~v_o)) begin
      error_r <= 1'b1;
    end
  end

  assign error_o = error_r;
`else
  assign error_o = 1'b0;
`endif

endmodule
